fill_row_writer: RTL and testbench
==================================

# fill_row_writer

Row-span pixel writer on the responder side of the fill controller's `fill_start` / `fill_done` / `fill_complete` handshake. When the controller raises `fill_start`, the block latches the current row's span and colour. It then emits one framebuffer write request per pixel through a valid/ready interface. It ends each row with a `fill_done` pulse, plus a `fill_complete` level that says whether this was the shape's last row. It sits between the fill controller, the row/edge block that supplies the span, and the framebuffer write arbiter.

## Interface
- `X_W`, default 10: x coordinate width.
- `Y_W`, default 9: y coordinate width.
- `COLOR_W`, default 24: pixel colour width.
- `X_MAX`, default 640: screen width in pixels. Pixels with x ≥ `X_MAX` are clipped.
- `clk  in  1`: system clock; all state updates on the rising edge.
- `n_rst  in  1`: asynchronous, active-low reset.
- `fill_start  in  1`: level request from the controller, held high until it sees `fill_done`.
- `row_y  in  Y_W`: current scan row; sampled on request accept.
- `x_left  in  X_W`, `x_right  in  X_W`: span endpoints, inclusive, either order; sampled on accept.
- `y_last  in  Y_W`: final row of the shape; sampled on accept.
- `fill_color  in  COLOR_W`: fill colour; sampled on accept.
- `wr_ready  in  1`: framebuffer arbiter accepts the current write.
- `wr_valid  out  1`: write request valid.
- `wr_x  out  X_W`, `wr_y  out  Y_W`, `wr_color  out  COLOR_W`: write address and data.
- `fill_done  out  1`: one-cycle pulse when the row is finished.
- `fill_complete  out  1`: registered level, 1 when the finished row was the last row.
- `busy  out  1`: high in every state except IDLE.

## Operation
- States:
  - IDLE: waiting for a request.
  - WRITE: issuing pixel writes.
  - DONE: pulsing `fill_done`.
  - RELEASE: waiting for `fill_start` to drop.
- Transitions:
  - IDLE, `fill_start`=1 → WRITE. Latch lo = min(x_left, x_right) and hi = min(max(x_left, x_right), `X_MAX`−1), plus `row_y`, `y_last` and `fill_color`. If lo > `X_MAX`−1 the span is empty and the next state is DONE instead.
  - WRITE, handshake (`wr_valid`&`wr_ready`) with x == hi → DONE. Any other handshake → x+1, stay in WRITE. No handshake → hold everything.
  - DONE → RELEASE, unconditionally.
  - RELEASE, `fill_start`=0 → IDLE; otherwise stay.
- `wr_valid` = 1 only in WRITE. `wr_x` = the current x counter, `wr_y` = latched row, `wr_color` = latched colour.
- `fill_done` = 1 only in DONE.
- `fill_complete` is loaded in the IDLE→WRITE/DONE transition cycle with (`row_y` ≥ `y_last`), unsigned compare. It holds until the next accept.
- `x_left == x_right` → exactly one write.
- Inputs other than `fill_start` and `wr_ready` are ignored outside the accept cycle.
- A drop of `fill_start` during WRITE is ignored: the span always completes (no abort).
- RELEASE guarantees one request produces exactly one `fill_done`, even though `fill_start` is still high in the DONE cycle.

## Timing
- Reset values: state IDLE; `wr_valid`, `fill_done`, `fill_complete`, `busy` = 0; `wr_x`, `wr_y`, `wr_color` = 0.
- Reset is asynchronous at any point, including mid-span: all outputs return to reset values immediately and no further writes occur. A `fill_start` still high after reset release is treated as a new request.
- Accept latency: `fill_start` sampled high at edge N → `wr_valid` = 1 from cycle N+1, with `wr_x` = lo.
- Throughput: with `wr_ready` held 1, one pixel per cycle. An N-pixel span produces `wr_valid` for cycles N+1..N+N and `fill_done` in cycle N+N+1.
- Empty (fully clipped) span: `fill_done` in cycle N+1 and no writes.
- Backpressure: while `wr_valid`=1 and `wr_ready`=0, `wr_x`, `wr_y`, `wr_color` must stay stable. `wr_valid` never drops before the handshake.
- `fill_complete` is valid no later than the `fill_done` cycle and stable through the following cycle, when the controller samples it.
- Earliest re-accept: the cycle after `fill_start` is seen low in RELEASE.

## Test plan
- Basic row:
  - Stimulus: `x_left`=10, `x_right`=13, `row_y`=5, `y_last`=8, colour 0xFF0000, `wr_ready`=1.
  - Response: writes (10..13, 5) on four consecutive cycles; one `fill_done` pulse the next cycle; `fill_complete`=0.
- Reversed span:
  - Stimulus: `x_left`=20, `x_right`=17, `row_y`=8, `y_last`=8.
  - Response: writes x=17..20 in order; `fill_complete`=1 and held until the next accept.
- Backpressure:
  - Stimulus: span 0..2 with `wr_ready` pattern 0,0,1,0,1,1.
  - Response: `wr_x` stays 0 for three cycles and then advances only on ready cycles; exactly three handshakes; `fill_done` after the last one.
- Clipping:
  - Stimulus: span 636..700, `X_MAX`=640.
  - Response: writes x=636..639 only.
  - Stimulus: span 650..660.
  - Response: no writes; `fill_done` one cycle after accept.
- Single pixel and hold:
  - Stimulus: `x_left`=`x_right`=3, `fill_start` held high 5 cycles after `fill_done`.
  - Response: one write; exactly one `fill_done`; `busy` stays 1 until `fill_start` drops.
- Reset mid-span:
  - Stimulus: span 0..99, assert `n_rst`=0 after 10 handshakes.
  - Response: `wr_valid`, `busy`, `fill_complete` go 0 immediately; no `fill_done`; a fresh request after reset restarts at x=lo.

Source files
------------

// File: rtl/fill_row_writer.sv
`default_nettype none
// ============================================================================
// Module   : fill_row_writer
// Brief    : Latches one row span on a fill_start request and issues one
//            framebuffer write per pixel, closing the row with fill_done.
// Revision : 1.0 - initial release
// ============================================================================
module fill_row_writer #(
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 9,
    parameter int unsigned COLOR_W = 24,
    parameter int unsigned X_MAX   = 640
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               fill_start,
    input  logic [Y_W-1:0]     row_y,
    input  logic [X_W-1:0]     x_left,
    input  logic [X_W-1:0]     x_right,
    input  logic [Y_W-1:0]     y_last,
    input  logic [COLOR_W-1:0] fill_color,
    input  logic               wr_ready,
    output logic               wr_valid,
    output logic [X_W-1:0]     wr_x,
    output logic [Y_W-1:0]     wr_y,
    output logic [COLOR_W-1:0] wr_color,
    output logic               fill_done,
    output logic               fill_complete,
    output logic               busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WRITE   = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [X_W-1:0] C_X_LAST = X_W'(X_MAX - 1);
    localparam logic [X_W-1:0] C_X_ONE  = X_W'(1);

    logic [1:0]         state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [X_W-1:0]     hi_q, hi_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               complete_q, complete_d;

    logic [X_W-1:0]     w_lo;
    logic [X_W-1:0]     w_max;
    logic [X_W-1:0]     w_hi;
    logic               w_empty;
    logic               w_accept;
    logic               w_hs;

    // Span normalisation: endpoints may arrive in either order, right edge clipped.
    always_comb begin
        w_lo     = (x_left <= x_right) ? x_left : x_right;
        w_max    = (x_left <= x_right) ? x_right : x_left;
        w_hi     = (w_max > C_X_LAST) ? C_X_LAST : w_max;
        w_empty  = (w_lo > C_X_LAST);
        w_accept = (state_q == S_IDLE) && fill_start;
        w_hs     = (state_q == S_WRITE) && wr_ready;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    state_d = w_empty ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_ready && (x_q == hi_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Holds off re-acceptance so a still-high request yields one fill_done.
                if (!fill_start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_valid  = (state_q == S_WRITE);
        fill_done = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    always_comb begin
        x_d        = x_q;
        hi_d       = hi_q;
        y_d        = y_q;
        color_d    = color_q;
        complete_d = complete_q;
        if (w_accept) begin
            x_d        = w_lo;
            hi_d       = w_hi;
            y_d        = row_y;
            color_d    = fill_color;
            complete_d = (row_y >= y_last);
        end else if (w_hs && (x_q != hi_q)) begin
            x_d = x_q + C_X_ONE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_q        <= '0;
            hi_q       <= '0;
            y_q        <= '0;
            color_q    <= '0;
            complete_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            hi_q       <= hi_d;
            y_q        <= y_d;
            color_q    <= color_d;
            complete_q <= complete_d;
        end
    end

    assign wr_x          = x_q;
    assign wr_y          = y_q;
    assign wr_color      = color_q;
    assign fill_complete = complete_q;

endmodule
`default_nettype wire

// File: tb/tb_fill_row_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fill_row_writer
// Brief    : Self-checking bench: row vector table plus scoreboard of writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fill_row_writer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        fill_start = 1'b0;
    logic [8:0]  row_y = '0;
    logic [9:0]  x_left = '0;
    logic [9:0]  x_right = '0;
    logic [8:0]  y_last = '0;
    logic [23:0] fill_color = '0;
    logic        wr_ready = 1'b1;
    logic        wr_valid;
    logic [9:0]  wr_x;
    logic [8:0]  wr_y;
    logic [23:0] wr_color;
    logic        fill_done;
    logic        fill_complete;
    logic        busy;

    fill_row_writer #(.X_W(10), .Y_W(9), .COLOR_W(24), .X_MAX(640)) dut (
        .clk(clk), .n_rst(n_rst), .fill_start(fill_start), .row_y(row_y),
        .x_left(x_left), .x_right(x_right), .y_last(y_last),
        .fill_color(fill_color), .wr_ready(wr_ready), .wr_valid(wr_valid),
        .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .fill_done(fill_done),
        .fill_complete(fill_complete), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
    } wr_t;

    typedef struct {
        int xl;
        int xr;
        int ry;
        int yl;
        int col;
        int cmp;
        int hold;
    } vec_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  hs_cnt = 0;
    int  done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every handshake must match the next expected pixel in order.
    always @(negedge clk) begin
        if (n_rst && wr_valid && wr_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_x", 32'(wr_x), 32'(e.x));
                chk("wr_y", 32'(wr_y), 32'(e.y));
                chk("wr_color", 32'(wr_color), 32'(e.c));
            end
        end
        if (fill_done) done_cnt++;
    end

    task automatic push_span(input int xl, input int xr, input int ry, input int col);
        int lo, hi;
        lo = (xl < xr) ? xl : xr;
        hi = (xl < xr) ? xr : xl;
        if (hi > 639) hi = 639;
        for (int x = lo; x <= hi; x++) exp_q.push_back('{x, ry, col});
    endtask

    task automatic drive_req(input int xl, input int xr, input int ry, input int yl, input int col);
        x_left     = 10'(xl);
        x_right    = 10'(xr);
        row_y      = 9'(ry);
        y_last     = 9'(yl);
        fill_color = 24'(col);
        fill_start = 1'b1;
    endtask

    task automatic release_req(input int d0, input int cmp);
        @(posedge clk); #1;
        fill_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("busy_after_release", 32'(busy), 32'd0);
        chk("complete_held_idle", 32'(fill_complete), 32'(cmp));
        chk("one_done_per_req", 32'(done_cnt - d0), 32'd1);
        chk("all_writes_seen", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_row(input vec_t v);
        int lo, hi, npix, cyc, d0;
        lo = (v.xl < v.xr) ? v.xl : v.xr;
        hi = (v.xl < v.xr) ? v.xr : v.xl;
        if (hi > 639) hi = 639;
        npix = (lo > 639) ? 0 : hi - lo + 1;
        push_span(v.xl, v.xr, v.ry, v.col);
        d0 = done_cnt;
        @(posedge clk); #1;
        wr_ready = 1'b1;
        drive_req(v.xl, v.xr, v.ry, v.yl, v.col);
        @(posedge clk); #1;
        // Span inputs must be ignored once the request is accepted.
        x_left     = 10'($urandom);
        x_right    = 10'($urandom);
        row_y      = 9'($urandom);
        y_last     = 9'($urandom);
        fill_color = 24'($urandom);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("valid_after_accept", 32'(wr_valid), (npix > 0) ? 32'd1 : 32'd0);
        end while (!fill_done && cyc < 300);
        chk("done_latency", 32'(cyc), 32'(npix + 1));
        chk("complete_at_done", 32'(fill_complete), 32'(v.cmp));
        @(negedge clk);
        chk("complete_after_done", 32'(fill_complete), 32'(v.cmp));
        chk("done_is_pulse", 32'(fill_done), 32'd0);
        chk("busy_in_release", 32'(busy), 32'd1);
        repeat (v.hold) begin
            @(negedge clk);
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_no_done", 32'(fill_done), 32'd0);
        end
        release_req(d0, v.cmp);
    endtask

    vec_t tbl[6];
    logic pat[6];
    int   bp_x[6];

    initial begin
        int d0, guard, h0;
        tbl[0] = '{10, 13, 5, 8, 'hFF0000, 0, 0};
        tbl[1] = '{20, 17, 8, 8, 'h00FF00, 1, 0};
        tbl[2] = '{636, 700, 1, 2, 'h0000FF, 0, 0};
        tbl[3] = '{650, 660, 3, 3, 'h123123, 1, 0};
        tbl[4] = '{3, 3, 4, 9, 'hABCDEF, 0, 5};
        tbl[5] = '{0, 1, 300, 299, 'h555555, 1, 0};
        pat  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bp_x = '{0, 0, 0, 1, 1, 2};

        repeat (2) @(negedge clk);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_fill_done", 32'(fill_done), 32'd0);
        chk("rst_complete", 32'(fill_complete), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_x", 32'(wr_x), 32'd0);
        chk("rst_wr_y", 32'(wr_y), 32'd0);
        chk("rst_wr_color", 32'(wr_color), 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;

        for (int i = 0; i < 6; i++) run_row(tbl[i]);

        // Backpressure: outputs frozen while ready is low.
        push_span(0, 2, 7, 'h123456);
        d0 = done_cnt;
        @(posedge clk); #1;
        wr_ready = 1'b0;
        drive_req(0, 2, 7, 0, 'h123456);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            wr_ready = pat[i];
            @(negedge clk);
            chk("bp_valid", 32'(wr_valid), 32'd1);
            chk("bp_x", 32'(wr_x), 32'(bp_x[i]));
        end
        @(negedge clk);
        chk("bp_done", 32'(fill_done), 32'd1);
        release_req(d0, 1);

        // Reset in the middle of a long span, request still held high.
        push_span(0, 99, 9, 'h0F0F0F);
        d0 = done_cnt;
        h0 = hs_cnt;
        @(posedge clk); #1;
        wr_ready = 1'b1;
        drive_req(0, 99, 9, 3, 'h0F0F0F);
        guard = 0;
        while (hs_cnt < h0 + 10 && guard < 500) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("reach_10_hs", 32'(hs_cnt - h0 >= 10), 32'd1);
        @(posedge clk); #1;
        chk("complete_before_rst", 32'(fill_complete), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(wr_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_complete", 32'(fill_complete), 32'd0);
        exp_q.delete();
        drive_req(5, 0, 2, 2, 'h0A0B0C);
        push_span(5, 0, 2, 'h0A0B0C);
        repeat (2) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (guard == 1) chk("restart_x_lo", 32'(wr_x), 32'd0);
        end while (!fill_done && guard < 300);
        chk("restart_done_latency", 32'(guard), 32'd7);
        release_req(d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
